fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the MIPS pipeline, generalising EX/MEM + MEM/WB forwarding to FWD_STAGES tracked downstream stages.
- Keeps an internal shift-register scoreboard of in-flight writers, so it no longer needs per-stage rd/reg_write inputs from the pipeline registers.
- Adds load-use stall generation with a parametrised load-ready stage, plus flush handling.
- Sits beside the ID/EX register. Drives the ALU operand muxes, the PC/IF-ID write enables and the ID/EX bubble.

---
 rtl/fwd_hazard_unit.sv | 148 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit : scoreboard-based ALU forwarding and load-use stall unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_unit #(
    parameter int NUM_BITS   = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] if_id_rs,
    input  logic [NUM_BITS-1:0] if_id_rt,
    input  logic                if_id_uses_rt,
    input  logic [NUM_BITS-1:0] id_ex_rs,
    input  logic [NUM_BITS-1:0] id_ex_rt,
    input  logic [NUM_BITS-1:0] id_ex_rd,
    input  logic                id_ex_reg_write,
    input  logic                id_ex_mem_read,
    input  logic                flush,
    output logic [SEL_W-1:0]    forwarding_muxA,
    output logic [SEL_W-1:0]    forwarding_muxB,
    output logic                stall,
    output logic                bubble
);

    // Longest possible stall is LOAD_STAGE-1 <= 6 cycles.
    localparam int CNT_W = 3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    logic                trk_valid   [1:FWD_STAGES];
    logic [NUM_BITS-1:0] trk_rd      [1:FWD_STAGES];
    logic                trk_is_load [1:FWD_STAGES];

    logic                prod_load [0:FWD_STAGES];
    logic [NUM_BITS-1:0] prod_rd   [0:FWD_STAGES];

    state_t              state;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    hazard_n;
    logic [SEL_W-1:0]    sel_a;
    logic [SEL_W-1:0]    sel_b;

    // Shift register of in-flight writers; a bubble in EX shifts in as invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= FWD_STAGES; k++) begin
                trk_valid[k]   <= 1'b0;
                trk_rd[k]      <= '0;
                trk_is_load[k] <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 1; k <= FWD_STAGES; k++) begin
                trk_valid[k] <= 1'b0;
            end
        end else begin
            for (int k = FWD_STAGES; k >= 2; k--) begin
                trk_valid[k]   <= trk_valid[k-1];
                trk_rd[k]      <= trk_rd[k-1];
                trk_is_load[k] <= trk_is_load[k-1];
            end
            trk_valid[1]   <= id_ex_reg_write && (id_ex_rd != '0);
            trk_rd[1]      <= id_ex_rd;
            trk_is_load[1] <= id_ex_mem_read;
        end
    end

    // Oldest-to-youngest scan so the youngest matching entry decides.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (trk_valid[k] && (trk_rd[k] == id_ex_rs) && (id_ex_rs != '0)) begin
                sel_a = (trk_is_load[k] && (k < LOAD_STAGE)) ? '0 : SEL_W'(k);
            end
            if (trk_valid[k] && (trk_rd[k] == id_ex_rt) && (id_ex_rt != '0)) begin
                sel_b = (trk_is_load[k] && (k < LOAD_STAGE)) ? '0 : SEL_W'(k);
            end
        end
    end

    assign forwarding_muxA = sel_a;
    assign forwarding_muxB = sel_b;

    // Position 0 is the instruction currently in EX, k is tracker entry k.
    always_comb begin
        prod_load[0] = id_ex_mem_read;
        prod_rd[0]   = id_ex_rd;
        for (int k = 1; k <= FWD_STAGES; k++) begin
            prod_load[k] = trk_valid[k] && trk_is_load[k];
            prod_rd[k]   = trk_rd[k];
        end
    end

    always_comb begin
        hazard_n = '0;
        for (int p = LOAD_STAGE - 2; p >= 0; p--) begin
            if (prod_load[p] && (prod_rd[p] != '0) &&
                ((prod_rd[p] == if_id_rs) ||
                 (if_id_uses_rt && (prod_rd[p] == if_id_rt)))) begin
                hazard_n = CNT_W'(LOAD_STAGE - 1 - p);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else if (flush) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hazard_n > CNT_W'(1)) begin
                        stall_cnt <= hazard_n - CNT_W'(1);
                        state     <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    stall_cnt <= stall_cnt - CNT_W'(1);
                    if (stall_cnt == CNT_W'(1)) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    stall_cnt <= '0;
                end
            endcase
        end
    end

    // Held low during reset so an asserted reset never leaves a stray bubble.
    assign stall  = rst_n && ((state == ST_STALL) || (hazard_n != '0));
    assign bubble = stall;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit : vector table, reset corner case and random model check
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_rd;
    logic       d_ut, e_we, e_mr, fl;
    logic [1:0] a2, b2, a3, b3, a1, b1;
    logic       s2, s3, s1, bb2, bb3, bb1;

    fwd_hazard_unit #(.NUM_BITS(5), .FWD_STAGES(2), .LOAD_STAGE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .if_id_rs(d_rs), .if_id_rt(d_rt), .if_id_uses_rt(d_ut),
        .id_ex_rs(e_rs), .id_ex_rt(e_rt), .id_ex_rd(e_rd), .id_ex_reg_write(e_we),
        .id_ex_mem_read(e_mr), .flush(fl), .forwarding_muxA(a2), .forwarding_muxB(b2),
        .stall(s2), .bubble(bb2));

    fwd_hazard_unit #(.NUM_BITS(5), .FWD_STAGES(3), .LOAD_STAGE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .if_id_rs(d_rs), .if_id_rt(d_rt), .if_id_uses_rt(d_ut),
        .id_ex_rs(e_rs), .id_ex_rt(e_rt), .id_ex_rd(e_rd), .id_ex_reg_write(e_we),
        .id_ex_mem_read(e_mr), .flush(fl), .forwarding_muxA(a3), .forwarding_muxB(b3),
        .stall(s3), .bubble(bb3));

    fwd_hazard_unit #(.NUM_BITS(5), .FWD_STAGES(3), .LOAD_STAGE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .if_id_rs(d_rs), .if_id_rt(d_rt), .if_id_uses_rt(d_ut),
        .id_ex_rs(e_rs), .id_ex_rt(e_rt), .id_ex_rd(e_rd), .id_ex_reg_write(e_we),
        .id_ex_mem_read(e_mr), .flush(fl), .forwarding_muxA(a1), .forwarding_muxB(b1),
        .stall(s1), .bubble(bb1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: history of what was in EX k cycles ago, plus an
    // absolute-time lock for each configuration while a load is in flight.
    logic       hv [1:7];
    logic [4:0] hr [1:7];
    logic       hl [1:7];
    int         lock [3];
    int         cyc = 0;
    int         cfg_fs [3] = '{2, 3, 3};
    int         cfg_ls [3] = '{2, 3, 1};

    function automatic int m_fwd(input int fs, input int ls, input logic [4:0] src);
        int  sel = 0;
        bit  found = 0;
        for (int k = 1; k <= fs; k++) begin
            if (!found && hv[k] && hr[k] == src && src != 0) begin
                sel   = (hl[k] && k < ls) ? 0 : k;
                found = 1;
            end
        end
        return sel;
    endfunction

    function automatic int m_need(input int ls);
        int         n = 0;
        bit         found = 0;
        logic       ld;
        logic [4:0] rd;
        for (int p = 0; p <= ls - 2; p++) begin
            ld = (p == 0) ? e_mr : (hv[p] && hl[p]);
            rd = (p == 0) ? e_rd : hr[p];
            if (!found && ld && rd != 0 && (rd == d_rs || (d_ut && rd == d_rt))) begin
                n     = ls - 1 - p;
                found = 1;
            end
        end
        return n;
    endfunction

    task automatic model_edge();
        int n;
        if (!rst_n) begin
            for (int k = 1; k <= 7; k++) hv[k] = 1'b0;
            for (int c = 0; c < 3; c++) lock[c] = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                n = m_need(cfg_ls[c]);
                if (fl) lock[c] = 0;
                else if (!(cyc < lock[c]) && n > 0) lock[c] = cyc + n;
            end
            if (fl) begin
                for (int k = 1; k <= 7; k++) hv[k] = 1'b0;
            end else begin
                for (int k = 7; k >= 2; k--) begin
                    hv[k] = hv[k-1];
                    hr[k] = hr[k-1];
                    hl[k] = hl[k-1];
                end
                hv[1] = e_we && (e_rd != 0);
                hr[1] = e_rd;
                hl[1] = e_mr;
            end
        end
        cyc++;
    endtask

    task automatic check_model();
        int es, ea, eb;
        for (int c = 0; c < 3; c++) begin
            es = ((cyc < lock[c]) || (m_need(cfg_ls[c]) > 0)) ? 1 : 0;
            ea = m_fwd(cfg_fs[c], cfg_ls[c], e_rs);
            eb = m_fwd(cfg_fs[c], cfg_ls[c], e_rt);
            case (c)
                0: begin chk("rnd_a2", a2, ea); chk("rnd_b2", b2, eb);
                         chk("rnd_s2", s2, es); chk("rnd_bb2", bb2, es); end
                1: begin chk("rnd_a3", a3, ea); chk("rnd_b3", b3, eb);
                         chk("rnd_s3", s3, es); chk("rnd_bb3", bb3, es); end
                default: begin chk("rnd_a1", a1, ea); chk("rnd_b1", b1, eb);
                         chk("rnd_s1", s1, es); chk("rnd_bb1", bb1, es); end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic zero_inputs();
        d_rs = 0; d_rt = 0; d_ut = 0; e_rs = 0; e_rt = 0; e_rd = 0;
        e_we = 0; e_mr = 0; fl = 0;
    endtask

    typedef struct {
        logic [4:0] d_rs, d_rt;
        logic       d_ut;
        logic [4:0] e_rs, e_rt, e_rd;
        logic       e_we, e_mr, fl;
        int         a2, b2, s2, a3, b3, s3;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input int drs, input int drt, input int dut, input int ers,
                                input int ert, input int erd, input int we, input int mr,
                                input int f, input int xa2, input int xb2, input int xs2,
                                input int xa3, input int xb3, input int xs3);
        vec_t v;
        v.d_rs = 5'(drs); v.d_rt = 5'(drt); v.d_ut = 1'(dut);
        v.e_rs = 5'(ers); v.e_rt = 5'(ert); v.e_rd = 5'(erd);
        v.e_we = 1'(we);  v.e_mr = 1'(mr);  v.fl = 1'(f);
        v.a2 = xa2; v.b2 = xb2; v.s2 = xs2; v.a3 = xa3; v.b3 = xb3; v.s3 = xs3;
        return v;
    endfunction

    initial begin
        for (int k = 1; k <= 7; k++) begin hv[k] = 0; hr[k] = 0; hl[k] = 0; end
        for (int c = 0; c < 3; c++) lock[c] = 0;

        //          drs drt ut ers ert erd we mr fl  a2 b2 s2 a3 b3 s3
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 3, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 3, 3, 3, 1, 0, 0,  2, 2, 0, 2, 2, 0);
        vecs[4]  = mk(0, 0, 0, 3, 0, 3, 1, 0, 0,  1, 0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 3, 3, 0, 0, 0, 0,  1, 1, 0, 1, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0,  0, 0, 0, 0, 3, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 5, 1, 0, 0, 5, 1, 1, 0,  0, 0, 1, 0, 0, 1);
        vecs[10] = mk(0, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[11] = mk(0, 0, 0, 0, 5, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 5, 0, 0, 0, 0,  0, 0, 0, 0, 3, 0);
        vecs[13] = mk(7, 0, 0, 0, 0, 7, 1, 1, 0,  0, 0, 1, 0, 0, 1);
        vecs[14] = mk(7, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        vecs[15] = mk(0, 0, 0, 7, 7, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        zero_inputs();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("rst_a2", a2, 0); chk("rst_b2", b2, 0);
            chk("rst_s2", s2, 0); chk("rst_bb2", bb2, 0);
            chk("rst_s3", s3, 0); chk("rst_a3", a3, 0);
            tick();
        end
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            d_rs = vecs[i].d_rs; d_rt = vecs[i].d_rt; d_ut = vecs[i].d_ut;
            e_rs = vecs[i].e_rs; e_rt = vecs[i].e_rt; e_rd = vecs[i].e_rd;
            e_we = vecs[i].e_we; e_mr = vecs[i].e_mr; fl = vecs[i].fl;
            #2;
            chk($sformatf("v%0d_a2", i), a2, vecs[i].a2);
            chk($sformatf("v%0d_b2", i), b2, vecs[i].b2);
            chk($sformatf("v%0d_s2", i), s2, vecs[i].s2);
            chk($sformatf("v%0d_bb2", i), bb2, vecs[i].s2);
            chk($sformatf("v%0d_a3", i), a3, vecs[i].a3);
            chk($sformatf("v%0d_b3", i), b3, vecs[i].b3);
            chk($sformatf("v%0d_s3", i), s3, vecs[i].s3);
            chk($sformatf("v%0d_bb3", i), bb3, vecs[i].s3);
            tick();
        end

        // Asynchronous reset while the LOAD_STAGE=3 unit sits in its stall.
        zero_inputs();
        d_rs = 7; e_rd = 7; e_we = 1; e_mr = 1;
        #2;
        chk("mid_s2_hazard", s2, 1); chk("mid_s3_hazard", s3, 1); chk("mid_s1_never", s1, 0);
        tick();
        zero_inputs();
        d_rs = 7; e_rs = 7;
        #2;
        chk("mid_s3_stall", s3, 1); chk("mid_s2_done", s2, 0); chk("mid_a1_fwd", a1, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_s3", s3, 0); chk("arst_bb3", bb3, 0);
        chk("arst_a1", a1, 0); chk("arst_a3", a3, 0);
        tick();
        rst_n = 1'b1;
        #2;
        chk("post_rst_s3", s3, 0); chk("post_rst_a1", a1, 0); chk("post_rst_bb3", bb3, 0);
        tick();

        for (int i = 0; i < 600; i++) begin
            d_rs = 5'($urandom_range(0, 3));
            d_rt = 5'($urandom_range(0, 3));
            d_ut = 1'($urandom_range(0, 1));
            e_rs = 5'($urandom_range(0, 3));
            e_rt = 5'($urandom_range(0, 3));
            e_rd = 5'($urandom_range(0, 3));
            e_mr = ($urandom_range(0, 2) == 0);
            e_we = e_mr || ($urandom_range(0, 1) == 1);
            fl   = ($urandom_range(0, 15) == 0);
            #2;
            check_model();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
